alu_operand_stage: RTL

Operand-fetch and issue stage directly upstream of the 16-bit ALU. Holds the 16-entry register file, selects and forwards operands, and presents a registered `a`/`b`/`ALUOp` triple to the combinational ALU through a valid/ready handshake. The writeback stage downstream of the ALU returns results through the write port.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_operand_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and opcode encodings for the ALU operand stage
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int OP_W     = 3;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_OR    = 3'b000;
  localparam alu_op_t OP_AND   = 3'b001;
  localparam alu_op_t OP_ADD   = 3'b010;
  localparam alu_op_t OP_NEG   = 3'b100;
  localparam alu_op_t OP_NOT   = 3'b101;
  localparam alu_op_t OP_COMP  = 3'b110;
  localparam alu_op_t OP_SHIFT = 3'b111;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 2R1W register file, async reads, sync write, r0 reads zero
module alu_regfile import alu_pkg::*; #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = alu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << REG_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch/issue slot ahead of the combinational ALU
// ALU_OPERAND_FWD_EN: forward alu_r from the slot; undefined: stall on RAW hazards instead
module alu_operand_stage import alu_pkg::*; #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] alu_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   ALUOp,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr
);

  logic [DATA_W-1:0] rf_rs;
  logic [DATA_W-1:0] rf_rt;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              rs_slot_hit;
  logic              rt_slot_hit;
  logic              rs_wb_hit;
  logic              rt_wb_hit;
  logic              hazard;
  logic              accept;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (in_rs),
    .rdata_a (rf_rs),
    .raddr_b (in_rt),
    .rdata_b (rf_rt)
  );

  // r0 never matches a producer, so the regfile's zero read covers priority 1
  assign rs_slot_hit = out_valid && out_wr && (in_rs != '0) && (out_rd == in_rs);
  assign rt_slot_hit = out_valid && out_wr && (in_rt != '0) && (out_rd == in_rt);
  assign rs_wb_hit   = wb_en && (in_rs != '0) && (wb_addr == in_rs);
  assign rt_wb_hit   = wb_en && (in_rt != '0) && (wb_addr == in_rt);

`ifdef ALU_OPERAND_FWD_EN

  assign hazard = 1'b0;

  always_comb begin
    rs_val = rf_rs;
    if (rs_slot_hit) begin
      rs_val = alu_r;
    end else if (rs_wb_hit) begin
      rs_val = wb_data;
    end
  end

  always_comb begin
    rt_val = rf_rt;
    if (rt_slot_hit) begin
      rt_val = alu_r;
    end else if (rt_wb_hit) begin
      rt_val = wb_data;
    end
  end

`else

  logic              pend_valid;
  logic [REG_AW-1:0] pend_rd;
  logic              rs_pend;
  logic              rt_pend;
  logic              alu_r_unused;

  assign alu_r_unused = ^alu_r;

  assign rs_val = rs_wb_hit ? wb_data : rf_rs;
  assign rt_val = rt_wb_hit ? wb_data : rf_rt;

  assign rs_pend = pend_valid && (in_rs != '0) && (pend_rd == in_rs);
  assign rt_pend = pend_valid && (in_rt != '0) && (pend_rd == in_rt);

  assign hazard = in_valid &&
                  ((rs_slot_hit || rs_pend) || (!in_use_imm && (rt_slot_hit || rt_pend)));

  // A new handshake overrides a same-cycle clear: the younger destination is still owed a write
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_rd    <= '0;
    end else if (out_valid && out_ready && out_wr && (out_rd != '0)) begin
      pend_valid <= 1'b1;
      pend_rd    <= out_rd;
    end else if (pend_valid && wb_en && (wb_addr == pend_rd)) begin
      pend_valid <= 1'b0;
    end
  end

`endif

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      ALUOp     <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a         <= rs_val;
      b         <= in_use_imm ? in_imm : rt_val;
      ALUOp     <= in_op;
      out_rd    <= in_rd;
      out_wr    <= in_wr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
